// File: rtl/mux_pkg.sv
// Shared types and helpers for the LED multiplexing row sequencer.
package mux_pkg;

    localparam int NB_MUX_ROWS = 4;

    // One-hot multiplexing row; all zeros means no row is lit.
    typedef logic [NB_MUX_ROWS-1:0] mux_row_t;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        WAIT,
        BLANK,
        LATCH
    } mux_seq_state_t;

    // Rotation 0000 -> 0001 -> 0010 -> 0100 -> 1000 -> 0001.
    function automatic mux_row_t next_mux_row(input mux_row_t row);
        mux_row_t nxt;
        if (row == '0) begin
            nxt = {{(NB_MUX_ROWS-1){1'b0}}, 1'b1};
        end else begin
            nxt = {row[NB_MUX_ROWS-2:0], row[NB_MUX_ROWS-1]};
        end
        return nxt;
    endfunction

endpackage

// File: rtl/row_timer.sv
// Saturating count of cycles since the current row was lit, plus the
// derived shift deadline flags.
module row_timer #(
    parameter int ROW_PERIOD = 64,
    parameter int DEAD_TIME  = 4
) (
    input  logic clk,
    input  logic nrst,
    input  logic i_clear,     // restart at 0 on the next cycle
    input  logic i_row_lit,   // a multiplexing row is currently selected
    output logic o_deadline,  // shifting must be finished by now
    output logic o_late       // the deadline was already behind us
);

    localparam int TW = $clog2(ROW_PERIOD);
    localparam logic [TW-1:0] T_MAX      = TW'(ROW_PERIOD - 1);
    localparam logic [TW-1:0] T_DEADLINE = TW'(ROW_PERIOD - DEAD_TIME - 2);

    logic [TW-1:0] r_count;

    // Count lit cycles, holding at the row period limit.
    // NOTE: non-blocking assignments so every flop updates from pre-edge values.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (r_count != T_MAX) begin
            r_count <= r_count + TW'(1);
        end
    end

    // With no row lit there is nothing to protect, so the deadline is
    // always considered reached but never missed.
    assign o_deadline = !i_row_lit || (r_count >= T_DEADLINE);
    assign o_late     = i_row_lit && (r_count > T_DEADLINE);

endmodule

// File: rtl/mux_row_sequencer.sv
// Steps the four multiplexing rows, scans the driver output index while a
// row is lit, then blanks, latches and moves to the next row.
module mux_row_sequencer
    import mux_pkg::*;
#(
    parameter int NB_LEDS_PER_GROUP = 16,
    parameter int ROW_PERIOD        = 64,
    parameter int DEAD_TIME         = 4,
    localparam int LED_W            = $clog2(NB_LEDS_PER_GROUP)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             enable,
    input  logic             frame_sync,
    input  logic             led_ready,
    output mux_row_t         row_en,
    output logic [LED_W-1:0] led,
    output logic             led_valid,
    output logic             latch,
    output logic             overrun
);

    localparam int BW = $clog2(DEAD_TIME + 1);
    localparam logic [LED_W-1:0] LED_LAST   = LED_W'(NB_LEDS_PER_GROUP - 1);
    localparam logic [BW-1:0]    BLANK_LAST = BW'(DEAD_TIME - 1);

    mux_seq_state_t   r_state,     w_state_nxt;
    mux_row_t         r_cur_row,   w_cur_row_nxt;
    logic [LED_W-1:0] r_led,       w_led_nxt;
    logic [BW-1:0]    r_blank_cnt, w_blank_cnt_nxt;
    logic             r_overrun,   w_overrun_nxt;
    logic             r_pending,   w_pending_nxt;

    mux_row_t         r_row_en;
    logic             r_led_valid;
    logic             r_latch;

    logic             w_deadline;
    logic             w_late;
    logic             w_timer_clear;
    logic             w_handshake;

    assign w_handshake   = r_led_valid && led_ready;
    // Restart the timer whenever the selected row changes, and keep it at 0
    // while no row is lit.
    assign w_timer_clear = (w_cur_row_nxt != r_cur_row) || (r_cur_row == '0);

    row_timer #(
        .ROW_PERIOD (ROW_PERIOD),
        .DEAD_TIME  (DEAD_TIME)
    ) u_row_timer (
        .clk        (clk),
        .nrst       (nrst),
        .i_clear    (w_timer_clear),
        .i_row_lit  (r_cur_row != '0),
        .o_deadline (w_deadline),
        .o_late     (w_late)
    );

    // Next-state and next-value logic for the sequencer.
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        w_state_nxt     = r_state;
        w_cur_row_nxt   = r_cur_row;
        w_led_nxt       = r_led;
        w_blank_cnt_nxt = '0;
        w_overrun_nxt   = r_overrun;
        w_pending_nxt   = r_pending | frame_sync;

        case (r_state)
            IDLE: begin
                // Already aligned to row 0, so a frame_sync here is dropped.
                w_pending_nxt = 1'b0;
                w_cur_row_nxt = '0;
                w_led_nxt     = '0;
                if (enable) begin
                    w_state_nxt = SHIFT;
                end else begin
                    w_overrun_nxt = 1'b0;
                end
            end
            SHIFT: begin
                if (w_handshake) begin
                    if (r_led == LED_LAST) begin
                        w_led_nxt = '0;
                        if (w_deadline) begin
                            w_state_nxt = BLANK;
                            if (w_late) begin
                                w_overrun_nxt = 1'b1;
                            end
                        end else begin
                            w_state_nxt = WAIT;
                        end
                    end else begin
                        w_led_nxt = r_led + LED_W'(1);
                    end
                end
            end
            WAIT: begin
                if (w_deadline) begin
                    w_state_nxt = BLANK;
                end
            end
            BLANK: begin
                if (r_blank_cnt == BLANK_LAST) begin
                    if (r_pending) begin
                        // Realign: reshift for row 0 with nothing lit.
                        w_pending_nxt = 1'b0;
                        w_cur_row_nxt = '0;
                        w_state_nxt   = SHIFT;
                    end else begin
                        w_state_nxt = LATCH;
                    end
                end else begin
                    w_blank_cnt_nxt = r_blank_cnt + BW'(1);
                end
            end
            LATCH: begin
                if (enable) begin
                    w_cur_row_nxt = next_mux_row(r_cur_row);
                    w_state_nxt   = SHIFT;
                end else begin
                    w_cur_row_nxt = '0;
                    w_state_nxt   = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= IDLE;
            r_cur_row   <= '0;
            r_led       <= '0;
            r_blank_cnt <= '0;
            r_overrun   <= 1'b0;
            r_pending   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cur_row   <= w_cur_row_nxt;
            r_led       <= w_led_nxt;
            r_blank_cnt <= w_blank_cnt_nxt;
            r_overrun   <= w_overrun_nxt;
            r_pending   <= w_pending_nxt;
        end
    end

    // Output registers decoded from the next state so they line up with it.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_row_en    <= '0;
            r_led_valid <= 1'b0;
            r_latch     <= 1'b0;
        end else begin
            r_row_en    <= (w_state_nxt == BLANK || w_state_nxt == LATCH) ? '0 : w_cur_row_nxt;
            r_led_valid <= (w_state_nxt == SHIFT);
            r_latch     <= (w_state_nxt == LATCH);
        end
    end

    assign row_en    = r_row_en;
    assign led       = r_led;
    assign led_valid = r_led_valid;
    assign latch     = r_latch;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_mux_row_sequencer.sv
// Scoreboard bench for mux_row_sequencer: stimulus pushes expected led
// indices and expected latch events; a monitor pops and compares them.
module tb_mux_row_sequencer;

    localparam int NB_LEDS = 16;
    localparam int LED_W   = 4;

    logic             clk = 1'b0;
    logic             nrst = 1'b0;
    logic             enable = 1'b0;
    logic             frame_sync = 1'b0;
    logic             led_ready = 1'b0;
    logic [3:0]       row_en;
    logic [LED_W-1:0] led;
    logic             led_valid;
    logic             latch;
    logic             overrun;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Expected properties of one latch pulse, measured since the previous
    // latch (or since the anchor cycle set by the stimulus).
    typedef struct {
        int         gap;       // cycles since previous latch / anchor
        int         blanks;    // cycles with row_en == 0 and no latch in that span
        int         hs;        // led handshakes in that span
        logic [3:0] next_row;  // row_en on the cycle after the latch
        logic       ovr;       // overrun seen during the latch cycle
    } exp_ev_t;

    exp_ev_t q_ev[$];
    int      q_led[$];

    int         last_latch_cyc = 0;
    int         blank_run = 0;
    int         hs_cnt = 0;
    bit         chk_next = 1'b0;
    logic [3:0] exp_next = '0;
    bit         prev_hold = 1'b0;
    logic [3:0] prev_led = '0;
    bit         expect_idle = 1'b0;

    mux_row_sequencer #(
        .NB_LEDS_PER_GROUP (NB_LEDS),
        .ROW_PERIOD        (64),
        .DEAD_TIME         (4)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .enable     (enable),
        .frame_sync (frame_sync),
        .led_ready  (led_ready),
        .row_en     (row_en),
        .led        (led),
        .led_valid  (led_valid),
        .latch      (latch),
        .overrun    (overrun)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Advance n cycles, landing 2 time units after the rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic anchor();
        last_latch_cyc = cyc;
        blank_run      = 0;
        hs_cnt         = 0;
        prev_hold      = 1'b0;
        chk_next       = 1'b0;
    endtask

    task automatic push_row_leds();
        for (int i = 0; i < NB_LEDS; i++) q_led.push_back(i);
    endtask

    task automatic push_ev(input int gap, input int blanks, input int hs,
                           input logic [3:0] next_row, input logic ovr);
        exp_ev_t ev;
        ev.gap      = gap;
        ev.blanks   = blanks;
        ev.hs       = hs;
        ev.next_row = next_row;
        ev.ovr      = ovr;
        q_ev.push_back(ev);
    endtask

    task automatic wait_latch(input int max_cycles);
        bit seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            step(1);
            if (latch) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail("latch_timeout");
    endtask

    task automatic check_reset_outputs();
        check("rst_row_en",    32'(row_en),    32'd0);
        check("rst_led",       32'(led),       32'd0);
        check("rst_led_valid", 32'(led_valid), 32'd0);
        check("rst_latch",     32'(latch),     32'd0);
        check("rst_overrun",   32'(overrun),   32'd0);
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        exp_ev_t ev;
        int      e;
        forever begin
            @(negedge clk);
            if (nrst) begin
                check("row_en_onehot", 32'($countones(row_en) <= 1), 32'd1);
                if (expect_idle) begin
                    check("idle_row_en",    32'(row_en),    32'd0);
                    check("idle_led_valid", 32'(led_valid), 32'd0);
                    check("idle_latch",     32'(latch),     32'd0);
                end
                if (prev_hold && led_valid) check("led_stable", 32'(led), 32'(prev_led));
                if (led_valid && led_ready) begin
                    if (q_led.size() == 0) begin
                        fail("unexpected_handshake");
                    end else begin
                        e = q_led.pop_front();
                        check("led_index", 32'(led), 32'(e));
                    end
                    hs_cnt++;
                end
                if (chk_next) begin
                    check("row_after_latch", 32'(row_en), 32'(exp_next));
                    chk_next = 1'b0;
                end
                if (latch) begin
                    check("row_en_at_latch", 32'(row_en), 32'd0);
                    if (q_ev.size() == 0) begin
                        fail("unexpected_latch");
                    end else begin
                        ev = q_ev.pop_front();
                        check("latch_gap",        32'(cyc - last_latch_cyc), 32'(ev.gap));
                        check("blank_cycles",     32'(blank_run),            32'(ev.blanks));
                        check("handshakes",       32'(hs_cnt),               32'(ev.hs));
                        check("overrun_at_latch", 32'(overrun),              32'(ev.ovr));
                        chk_next = 1'b1;
                        exp_next = ev.next_row;
                    end
                    last_latch_cyc = cyc;
                    blank_run      = 0;
                    hs_cnt         = 0;
                end else if (row_en == 4'b0000) begin
                    blank_run++;
                end
                prev_hold = led_valid && !led_ready;
                prev_led  = led;
            end
        end
    end

    // Safety net in case something stalls outside the bounded waits.
    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: bench did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // Stimulus.
    initial begin
        // Reset held, then 20 idle cycles with enable low.
        step(3);
        check_reset_outputs();
        nrst        = 1'b1;
        expect_idle = 1'b1;
        step(20);
        expect_idle = 1'b0;

        // Startup and four steady rows with led_ready high. The anchor cycle
        // is the one in which enable is driven; its own IDLE cycle counts as
        // blank, then 16 shift cycles and 4 blank cycles, latch 21 cycles on.
        anchor();
        push_row_leds();
        push_ev(21, 21, 16, 4'b0001, 1'b0);
        push_row_leds(); push_ev(64, 4, 16, 4'b0010, 1'b0);
        push_row_leds(); push_ev(64, 4, 16, 4'b0100, 1'b0);
        push_row_leds(); push_ev(64, 4, 16, 4'b1000, 1'b0);
        push_row_leds(); push_ev(64, 4, 16, 4'b0001, 1'b0);
        enable    = 1'b1;
        led_ready = 1'b1;
        repeat (5) wait_latch(200);

        // led_ready toggling every cycle during row 0001.
        begin
            bit seen = 1'b0;
            push_row_leds();
            push_ev(64, 4, 16, 4'b0010, 1'b0);
            for (int i = 0; i < 200; i++) begin
                led_ready = !led_ready;
                step(1);
                if (latch) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (!seen) fail("latch_timeout_toggle");
        end

        // led_ready low for 60 cycles during row 0010: shifting ends at
        // lit cycle 74, then 4 blank and the latch -> 80 cycles, overrun set.
        push_row_leds();
        push_ev(80, 4, 16, 4'b0100, 1'b1);
        led_ready = 1'b0;
        step(60);
        led_ready = 1'b1;
        wait_latch(200);

        // Following rows are back to 64 cycles; overrun stays set.
        push_row_leds(); push_ev(64, 4, 16, 4'b1000, 1'b1);
        push_row_leds(); push_ev(64, 4, 16, 4'b0001, 1'b1);
        push_row_leds(); push_ev(64, 4, 16, 4'b0010, 1'b1);
        push_row_leds(); push_ev(64, 4, 16, 4'b0100, 1'b1);
        repeat (4) wait_latch(200);

        // frame_sync during row 0100: 59 lit + 4 blank, no latch, 16-cycle
        // reshift with nothing lit, 4 blank, latch -> 84 cycles, 24 blank.
        push_row_leds();
        push_row_leds();
        push_ev(84, 24, 32, 4'b0001, 1'b1);
        step(10);
        check("row_en_at_sync", 32'(row_en), 32'd4);
        frame_sync = 1'b1;
        step(1);
        frame_sync = 1'b0;
        wait_latch(200);

        // Asynchronous reset while led = 7 in row 0001.
        push_row_leds();
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 100; i++) begin
                step(1);
                if (led_valid && led == 4'd7) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (!seen) fail("led7_timeout");
        end
        nrst = 1'b0;
        #1;
        check_reset_outputs();
        q_led.delete();
        q_ev.delete();
        chk_next = 1'b0;
        @(posedge clk);
        #1;
        step(2);

        // Release with enable high: restarts like a fresh startup.
        nrst = 1'b1;
        anchor();
        push_row_leds();
        push_ev(21, 21, 16, 4'b0001, 1'b0);
        push_row_leds();
        wait_latch(200);
        step(17);

        check("leds_outstanding",    32'(q_led.size()), 32'd0);
        check("latches_outstanding", 32'(q_ev.size()),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mux_row_sequencer.md
# mux_row_sequencer

Sequencer for the LED multiplexing scheme of one driver group. It steps the 4 multiplexing rows in a fixed rotation (one-hot `row_en`). While a row is lit, it scans the driver output index `led` so the parent can look up the matching LED row and shift the greyscale data for the next row. It then blanks all rows for a dead time, pulses the driver latch, and activates the next row. It sits between the frame timing logic and the greyscale driver shifter. Its `row_en`/`led` outputs feed the multiplexing lookup table, which maps the current one-hot row to the next row's table.

## Interface
- `NB_LEDS_PER_GROUP`, 16: driver outputs per group; `led` width = $clog2(NB_LEDS_PER_GROUP).
- `ROW_PERIOD`, 64: cycles per row in steady state; must be ≥ DEAD_TIME + NB_LEDS_PER_GROUP + 2.
- `DEAD_TIME`, 4: blanking cycles before each latch; must be ≥ 1.

Ports:
- `clk`  in  1  system clock.
- `nrst`  in  1  asynchronous active-low reset.
- `enable`  in  1  run request.
- `frame_sync`  in  1  one-cycle pulse; restarts the rotation at mux row 0.
- `led_ready`  in  1  driver shifter accepts the current `led` index.
- `row_en`  out  4  one-hot active multiplexing row; 0000 = none lit.
- `led`  out  $clog2(NB_LEDS_PER_GROUP)  driver output index being shifted.
- `led_valid`  out  1  `led` is valid (SHIFT state).
- `latch`  out  1  one-cycle driver latch pulse.
- `overrun`  out  1  sticky: shifting missed the row deadline.

## Operation
- Internal state: `cur_row` (one-hot, 0000 = none).
  - `row_en` = `cur_row` except in BLANK and LATCH, where it is 0000.
  - The next row is the rotation 0000→0001→0010→0100→1000→0001.
- `row_timer` counts cycles since `cur_row` became nonzero. It is 0 on the first lit cycle and saturates at ROW_PERIOD-1.
- The deadline is reached when `cur_row` = 0000, or when `row_timer` ≥ ROW_PERIOD-DEAD_TIME-2.
- States:
  - IDLE: `row_en` = 0000, `cur_row` = 0000, `led` = 0. When `enable` = 1, go to SHIFT next cycle.
  - SHIFT: `led_valid` = 1. On `led_valid && led_ready`, `led` increments. When index NB_LEDS_PER_GROUP-1 is accepted, `led` returns to 0 and the state goes to WAIT.
    - If the deadline had already passed at that acceptance, set `overrun` and go directly to BLANK.
  - WAIT: go to BLANK on the cycle after the deadline is reached.
  - BLANK: lasts DEAD_TIME cycles, then go to LATCH.
  - LATCH: `latch` = 1 for one cycle.
    - Next cycle: `cur_row` ← next row, `row_timer` ← 0, state ← SHIFT if `enable`, else IDLE with `cur_row` = 0000.
- `frame_sync` sets a pending flag in any non-IDLE state.
  - The flag is honored at the end of BLANK: skip LATCH, set `cur_row` = 0000, clear the flag, go to SHIFT.
  - A `frame_sync` in IDLE is ignored (already aligned to row 0).
- `enable` dropping mid-row does not abort the row. It is only sampled in IDLE and at LATCH.
- `overrun` is cleared only by reset or by being in IDLE with `enable` = 0.

## Timing
- Reset values: `row_en` = 0000, `led` = 0, `led_valid` = 0, `latch` = 0, `overrun` = 0, state IDLE, pending flag 0.
- All outputs are registered; no combinational path from inputs to outputs.
- Steady state, no backpressure: every row lasts exactly ROW_PERIOD cycles.
  - ROW_PERIOD-DEAD_TIME-1 lit cycles, then DEAD_TIME blank cycles, then 1 latch cycle.
- From IDLE with `led_ready` = 1, the first nonzero `row_en` (0001) appears NB_LEDS_PER_GROUP + DEAD_TIME + 2 cycles after `enable` is sampled high.
- `led` is stable while `led_valid && !led_ready`.
- `row_en` never has more than one bit set. It is always 0000 on the cycle `latch` = 1.
- Asynchronous reset mid-SHIFT immediately forces all reset values, including `row_en` = 0000.

## Structure
- Package `mux_pkg`:
  - `NB_MUX_ROWS` = 4.
  - `mux_row_t` (4-bit one-hot).
  - State enum `mux_seq_state_t` {IDLE, SHIFT, WAIT, BLANK, LATCH}.
  - Function `next_mux_row`.
- One sub-module: `row_timer` (saturating counter with synchronous clear; outputs the deadline flag).
- The lookup table is instantiated by the parent, driven from `row_en` and `led`.

## Test plan
Parameters for all scenarios: NB_LEDS_PER_GROUP = 16, ROW_PERIOD = 64, DEAD_TIME = 4.

- Reset, `enable` = 0 for 20 cycles -> `row_en` = 0000, `led_valid` = 0, `latch` = 0 throughout.
- `enable` = 1, `led_ready` = 1 -> `led` 0..15, first `latch` 21 cycles after `enable` is sampled, `row_en` = 0001 next cycle. Then 0010, 0100, 1000, 0001, each row exactly 64 cycles with 4 blank cycles.
- `led_ready` toggling 1/0 every cycle -> each index held until accepted, exactly 16 handshakes per row, row period still 64, `overrun` = 0.
- `led_ready` held 0 for 60 cycles in a row -> `overrun` = 1, that row is longer than 64 cycles, next rows return to 64.
- `frame_sync` pulse while `row_en` = 0100 -> row completes, BLANK, `row_en` = 0000 during the 16-index reshift with no preceding latch, then `latch`, then `row_en` = 0001.
- `nrst` low during SHIFT at `led` = 7 -> all outputs at reset values the same cycle. After release with `enable` = 1, the sequence restarts at `led` = 0 and `row_en` = 0000.
